// File: rtl/mem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_responder: 16x32 GP register file and SPI (mode 0) flash reader.     |
// | MEM_RESP_FASTREAD_EN: fast-read command 0x0B with 8 dummy clocks.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_responder #(
  parameter int unsigned SPI_HALF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dataSend,
  input  logic [1:0]  memType,
  input  logic [23:0] spiAddrOut,
  input  logic [3:0]  gpAddrOut,
  input  logic [31:0] memDataOut,
  input  logic [2:0]  dataPosOut,
  output logic        memReady,
  output logic [31:0] memDataIn,
  output logic [2:0]  dataPosIn,
  output logic        spiCsN,
  output logic        spiSclk,
  output logic        spiMosi,
  input  logic        spiMiso
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GP_ACK   = 3'd1,
    SPI_CMD  = 3'd2,
    SPI_ADDR = 3'd3,
`ifdef MEM_RESP_FASTREAD_EN
    SPI_DUMMY = 3'd4,
`endif
    SPI_DATA = 3'd5,
    DONE     = 3'd6
  } state_t;

`ifdef MEM_RESP_FASTREAD_EN
  localparam logic [7:0] SPI_CMD_BYTE = 8'h0B;
`else
  localparam logic [7:0] SPI_CMD_BYTE = 8'h03;
`endif
  localparam logic [7:0] HALF_M1 = 8'(SPI_HALF - 1);
  // First half-period is one clk longer so the whole read lands on the fixed latency.
  localparam logic [7:0] HALF_LD = 8'(SPI_HALF);

  function automatic logic [31:0] size_mask(input logic [2:0] sz);
    case (sz)
      3'b000:  size_mask = 32'h0000_00FF;
      3'b001:  size_mask = 32'h0000_FFFF;
      default: size_mask = 32'hFFFF_FFFF;
    endcase
  endfunction

  // Bytes arrive MSB-first into the shifter; first byte received lands in bits[7:0].
  function automatic logic [31:0] assemble(input logic [31:0] rx, input logic [2:0] sz);
    case (sz)
      3'b000:  assemble = {24'h0, rx[7:0]};
      3'b001:  assemble = {16'h0, rx[7:0], rx[15:8]};
      default: assemble = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        csn_q, csn_d, sclk_q, sclk_d, mosi_q, mosi_d, ready_q, ready_d;
  logic [31:0] rdata_q, rdata_d, tx_q, tx_d, rx_q, rx_d;
  logic [2:0]  pos_q, pos_d, size_q, size_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic [5:0]  bit_q, bit_d, last_bit;
  logic [31:0] gp_q [16];
  logic [31:0] gp_d [16];

  always_comb begin
    state_d = state_q;
    csn_d   = csn_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    ready_d = 1'b0;
    rdata_d = rdata_q;
    pos_d   = pos_q;
    size_d  = size_q;
    hcnt_d  = hcnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    gp_d    = gp_q;

    case (state_q)
      SPI_CMD:   last_bit = 6'd7;
      SPI_ADDR:  last_bit = 6'd23;
`ifdef MEM_RESP_FASTREAD_EN
      SPI_DUMMY: last_bit = 6'd7;
`endif
      default:   last_bit = (size_q == 3'b000) ? 6'd7 : (size_q == 3'b001) ? 6'd15 : 6'd31;
    endcase

    case (state_q)
      IDLE: begin
        if (dataSend && memType != 2'b00) begin
          case (memType)
            2'b10: begin
              ready_d = 1'b1;
              rdata_d = gp_q[gpAddrOut] & size_mask(dataPosOut);
              pos_d   = dataPosOut;
              state_d = GP_ACK;
            end
            2'b11: begin
              ready_d = 1'b1;
              rdata_d = '0;
              pos_d   = dataPosOut;
              case (dataPosOut)
                3'b000:  gp_d[gpAddrOut] = {gp_q[gpAddrOut][31:8], memDataOut[7:0]};
                3'b001:  gp_d[gpAddrOut] = {gp_q[gpAddrOut][31:16], memDataOut[15:0]};
                default: gp_d[gpAddrOut] = memDataOut;
              endcase
              state_d = GP_ACK;
            end
            default: begin
              csn_d   = 1'b0;
              sclk_d  = 1'b0;
              tx_d    = {SPI_CMD_BYTE, spiAddrOut};
              mosi_d  = SPI_CMD_BYTE[7];
              rx_d    = '0;
              size_d  = dataPosOut;
              hcnt_d  = HALF_LD;
              bit_d   = '0;
              state_d = SPI_CMD;
            end
          endcase
        end
      end
      GP_ACK, DONE: state_d = IDLE;
      default: begin
        hcnt_d = hcnt_q - 8'd1;
        if (hcnt_q == 8'd0) begin
          hcnt_d = HALF_M1;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            if (state_q == SPI_DATA) rx_d = {rx_q[30:0], spiMiso};
          end else begin
            // Falling spiSclk: present the next bit; shifter is zero-filled past the address.
            tx_d   = {tx_q[30:0], 1'b0};
            mosi_d = tx_q[30];
            bit_d  = bit_q + 6'd1;
            if (bit_q == last_bit) begin
              bit_d = '0;
              case (state_q)
                SPI_CMD:   state_d = SPI_ADDR;
`ifdef MEM_RESP_FASTREAD_EN
                SPI_ADDR:  state_d = SPI_DUMMY;
                SPI_DUMMY: state_d = SPI_DATA;
`else
                SPI_ADDR:  state_d = SPI_DATA;
`endif
                default: begin
                  state_d = DONE;
                  csn_d   = 1'b1;
                  mosi_d  = 1'b0;
                  ready_d = 1'b1;
                  rdata_d = assemble(rx_q, size_q);
                  pos_d   = size_q;
                end
              endcase
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      pos_q   <= '0;
      size_q  <= '0;
      hcnt_q  <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      for (int i = 0; i < 16; i++) gp_q[i] <= '0;
    end else begin
      state_q <= state_d;
      csn_q   <= csn_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      pos_q   <= pos_d;
      size_q  <= size_d;
      hcnt_q  <= hcnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      gp_q    <= gp_d;
    end
  end

  assign memReady  = ready_q;
  assign memDataIn = rdata_q;
  assign dataPosIn = pos_q;
  assign spiCsN    = csn_q;
  assign spiSclk   = sclk_q;
  assign spiMosi   = mosi_q;

endmodule
`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: SPI_HALF, 1, clk cycles per spiSclk half-period (legal 1..255).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 dataSend  input  1  request strobe from core memory controller, one cycle per request.
REQ-005 memType  input  2  request type: 00 none, 01 SPI read, 10 GP read, 11 GP write.
REQ-006 spiAddrOut  input  24  SPI flash byte address.
REQ-007 gpAddrOut  input  4  GP register index.
REQ-008 memDataOut  input  32  write data for GP write.
REQ-009 dataPosOut  input  3  access size: 000 byte, 001 half, 010 word; other codes treated as word.
REQ-010 memReady  output  1  one-cycle completion pulse.
REQ-011 memDataIn  output  32  read data, valid while memReady=1.
REQ-012 dataPosIn  output  3  echo of the size code of the completing request.
REQ-013 spiCsN, spiSclk, spiMosi  output  1 each  SPI flash chip select (active-low), clock (mode 0), data out.
REQ-014 spiMiso  input  1  SPI flash data in.

Function
REQ-015 States: IDLE, GP_ACK, SPI_CMD, SPI_ADDR, [SPI_DUMMY], SPI_DATA, DONE.
REQ-016 In IDLE, dataSend=1 with memType≠00 latches type, addresses, write data and size; memType=00 is ignored.
REQ-017 dataSend while not IDLE is ignored; no queueing, no error signal.
REQ-018 GP read: IDLE→GP_ACK; memReady=1 in the cycle after the sampling edge, memDataIn = gp[gpAddrOut] masked to size, zero-extended.
REQ-019 GP write: byte writes bits[7:0] only, half bits[15:0], word all; untouched bits retained; memReady=1 one cycle after the sampling edge, memDataIn=0.
REQ-020 SPI read: spiCsN falls on the cycle after the sampling edge; transmit command 0x03 then 24 address bits, MSB first; then receive 8·N bits, N=1/2/4 for byte/half/word.
REQ-021 Mode 0: spiSclk idles low; spiMosi changes on spiSclk falling; spiMiso sampled on the clk edge that raises spiSclk; each bit spans 2·SPI_HALF clk.
REQ-022 Received bytes assemble little-endian (first byte → bits[7:0]); each byte MSB first; unreceived upper bytes are 0.
REQ-023 After the last data bit, spiCsN=1 and state DONE; memReady pulses in DONE; total latency exactly 2+2·SPI_HALF·(32+8N) clk from the sampling edge.
REQ-024 memDataIn and dataPosIn hold their last values when memReady=0; memReady never high two consecutive cycles.
REQ-025 Bit counter holds 0..63; the address shifter wraps naturally at 24 bits (address 0xFFFFFF legal, no increment).
REQ-026 A new request is accepted in the cycle immediately after memReady (back-to-back allowed).

Reset
REQ-027 On rst: state IDLE, spiCsN=1, spiSclk=0, spiMosi=0, memReady=0, memDataIn=0, dataPosIn=0, all 16 GP registers=0, counters=0.
REQ-028 rst mid-transfer aborts immediately (spiCsN high asynchronously); no memReady for the aborted request.

Configuration
REQ-029 Macro MEM_RESP_FASTREAD_EN defined: command 0x0B, SPI_DUMMY state inserts 8 dummy spiSclk cycles (spiMosi=0) after the address; latency becomes 2+2·SPI_HALF·(40+8N).
REQ-030 Macro undefined: command 0x03, no SPI_DUMMY state, latency per REQ-023.

Verification
REQ-031 GP write word 0xDEADBEEF to idx 5, then GP read word idx 5 -> memReady 1 cycle after each request, read memDataIn=0xDEADBEEF, dataPosIn=010.
REQ-032 GP write byte 0x11 to idx 5 after REQ-031, read half -> memDataIn=0x0000BE11.
REQ-033 SPI_HALF=1, word read addr 0x123456, flash model returns 0xA1,0xB2,0xC3,0xD4 -> MOSI bits 0x03,0x12,0x34,0x56; memDataIn=0xD4C3B2A1; memReady at cycle 2+2·64=130.
REQ-034 SPI byte read with second dataSend issued mid-transfer -> second ignored, single memReady, memDataIn=0x000000A1.
REQ-035 rst asserted at bit 20 of an SPI read -> spiCsN=1 same cycle, no memReady, next GP read idx 5 returns 0.
REQ-036 MEM_RESP_FASTREAD_EN defined, SPI_HALF=2, word read -> command 0x0B, 8 dummy clocks, memReady at cycle 2+4·72=290.
